folded_lut_engine: RTL and testbench
====================================

Name: folded_lut_engine

Overview:
- Runtime-programmable N_IN-input boolean function generator.
- Truth table is loaded word-by-word over a valid/ready config port, then folded into 2^(N_IN-1) mux-entry codes drawn from {0, 1, d, ~d}, where d = in_vec[0].
- Input vectors are evaluated through a parametrised mux with a registered output.
- Successor to the fixed hand-folded 4-input mux functions in the lab datapaths; one block replaces per-function modules.

Parameters:
- N_IN, 4, number of function inputs (2..8); in_vec[N_IN-1] is the MSB of the minterm index.
- CFG_W, 4, config word width; must divide 2^N_IN.
- N_WORDS, 2^N_IN/CFG_W, derived (localparam): words per table load.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_start  in  1  pulse: begin (or restart) a table load.
- cfg_valid  in  1  cfg_data valid.
- cfg_data  in  CFG_W  table word; word k = truth-table bits [k*CFG_W +: CFG_W].
- cfg_ready  out  1  high only in LOADING.
- cfg_done  out  1  one-cycle pulse when folding completes.
- in_valid  in  1  in_vec valid.
- in_ready  out  1  high only in READY.
- in_vec  in  N_IN  input vector (minterm index).
- out_valid  out  1  y valid.
- y  out  1  function value.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset.
- Reset:
  - state = EMPTY; word counter = 0; table register = 0.
  - All codes = C_ZERO.
  - cfg_ready = in_ready = cfg_done = out_valid = y = 0.
- FSM states: EMPTY, LOADING, FOLD, READY.
  - EMPTY -> LOADING on cfg_start.
  - LOADING: each cycle with cfg_valid & cfg_ready, store word at counter and increment. On the accept of word N_WORDS-1 -> FOLD.
  - FOLD (exactly 1 cycle): code[j] = {tt[2j+1], tt[2j]} for j = 0..2^(N_IN-1)-1. cfg_done = 1 in the following cycle. -> READY.
  - READY -> LOADING on cfg_start. Word counter cleared; codes are kept but unused until the next FOLD.
- Code meaning: 00 -> y=0, 11 -> y=1, 10 -> y=d, 01 -> y=~d.
- Evaluation:
  - Accepted when in_valid & in_ready.
  - Select index j = in_vec[N_IN-1:1]; y computed from code[j] and in_vec[0].
  - Latency 1: out_valid and y are registered and appear the cycle after acceptance.
  - Back-to-back accepts give back-to-back outputs; no backpressure on the output side.
  - y holds its last value while out_valid = 0.
- Boundaries:
  - cfg_start during LOADING restarts the load: counter = 0, partial words discarded, stays in LOADING.
  - cfg_start during FOLD is ignored.
  - cfg_start and in_valid in the same READY cycle: cfg_start wins; the input is not accepted and out_valid = 0 next cycle.
  - An evaluation accepted in the cycle before leaving READY still produces its output, using the old codes.
  - cfg_valid outside LOADING is ignored; the counter does not change.
  - in_valid outside READY is ignored; no output.
  - reset asserted mid-load or mid-evaluation returns all state to reset values on the next edge; any pending out_valid is dropped.
  - Word counter wraps only via the LOADING -> FOLD transition; it never exceeds N_WORDS-1.

Decomposition:
- Package lut_pkg:
  - State enum lut_state_t {EMPTY, LOADING, FOLD, READY}.
  - 2-bit code typedef lut_code_t with constants C_ZERO = 2'b00, C_ND = 2'b01, C_D = 2'b10, C_ONE = 2'b11.
  - Function decode_code(code, d) -> logic.
- Sub-module mux_n_to_1 (parameter SEL_W): data[2^SEL_W-1:0], sel[SEL_W-1:0], y.
  - Instantiated with SEL_W = N_IN-1.
  - Its data inputs are the decoded per-entry bits decode_code(code[j], in_vec[0]).
  - Its output feeds the y register.

Test Plan:
- Reset, then in_valid = 1 with in_vec = 4'b1111 -> in_ready = 0, out_valid stays 0; cfg_ready = 0, all outputs 0.
- Load 16'h00FF as words F, F, 0, 0 -> cfg_done pulses 2 cycles after the 4th accept. Then in_vec = 0011 -> y = 1 and in_vec = 1000 -> y = 0, each one cycle later with out_valid = 1.
- Load 16'hAAAA (all codes C_D) -> in_vec 0101 -> y = 1; in_vec 1110 -> y = 0. Back-to-back inputs give consecutive out_valid = 1.
- Load 16'h6996 (4-input parity) -> in_vec 0111 -> y = 1; 0110 -> y = 0; 1111 -> y = 0.
- Restart and override:
  - Load two words of 0, pulse cfg_start, then load 16'hFFFF -> every in_vec gives y = 1, confirming the partial words were discarded.
  - In READY, assert cfg_start together with in_valid -> no out_valid next cycle, state goes to LOADING.
- Assert reset for one cycle while in LOADING after word 2 -> state EMPTY, cfg_ready = 0. Reloading 16'h00FF then works per scenario 2.

Source files
------------

// File: rtl/lut_pkg.sv
// Shared types for the folded LUT engine: FSM states, mux-entry codes and
// the helper that turns a code plus the LSB input into a function bit.
package lut_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FOLD    = 2'd2,
        READY   = 2'd3
    } lut_state_t;

    typedef logic [1:0] lut_code_t;

    localparam lut_code_t C_ZERO = 2'b00;
    localparam lut_code_t C_ND   = 2'b01;
    localparam lut_code_t C_D    = 2'b10;
    localparam lut_code_t C_ONE  = 2'b11;

    // A code selects one of {0, ~d, d, 1}; d is the minterm LSB.
    function automatic logic decode_code(input lut_code_t code, input logic d);
        logic v;
        case (code)
            C_ZERO:  v = 1'b0;
            C_ND:    v = ~d;
            C_D:     v = d;
            default: v = 1'b1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mux_n_to_1.sv
// Plain 2^SEL_W-to-1 bit multiplexer used as the folded LUT's evaluation mux.
module mux_n_to_1 #(
    parameter int SEL_W = 3
) (
    input  logic [2**SEL_W-1:0] data,
    input  logic [SEL_W-1:0]    sel,
    output logic                y
);

    // Pick the data bit addressed by sel.
    always_comb begin
        y = data[sel];
    end

endmodule

// File: rtl/folded_lut_engine.sv
// Runtime-programmable N_IN-input boolean function. A truth table is loaded
// word by word, folded into 2-bit mux-entry codes over the upper inputs, and
// input vectors are evaluated through a mux with a registered output.
module folded_lut_engine
    import lut_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int CFG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             cfg_ready,
    output logic             cfg_done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    output logic             y
);

    localparam int N_BITS  = 2**N_IN;
    localparam int N_WORDS = N_BITS / CFG_W;
    localparam int N_CODES = N_BITS / 2;
    localparam int SEL_W   = N_IN - 1;
    localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);

    lut_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_BITS-1:0] table_q, table_d;
    lut_code_t         codes_q [N_CODES];
    lut_code_t         codes_d [N_CODES];
    logic              cfg_done_q, cfg_done_d;
    logic              out_valid_q, out_valid_d;
    logic              y_q, y_d;

    logic               accept;
    logic [N_CODES-1:0] mux_data;
    logic               mux_y;

    // Handshake readiness depends only on the current state.
    always_comb begin
        cfg_ready = (state_q == LOADING);
        in_ready  = (state_q == READY);
    end

    // State machine: load control, word storage and the one-cycle fold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        codes_d = codes_q;
        case (state_q)
            EMPTY: begin
                if (cfg_start) begin
                    state_d = LOADING;
                    cnt_d   = '0;
                end
            end
            LOADING: begin
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (cfg_valid) begin
                    table_d[int'(cnt_q) * CFG_W +: CFG_W] = cfg_data;
                    if (cnt_q == LAST_WORD) begin
                        state_d = FOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FOLD: begin
                for (int j = 0; j < N_CODES; j++) begin
                    codes_d[j] = table_q[2*j +: 2];
                end
                state_d = READY;
            end
            READY: begin
                if (cfg_start) begin
                    state_d = LOADING;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = EMPTY;
                cnt_d   = '0;
            end
        endcase
    end

    // Decode every mux entry against the LSB so the mux sees plain bits.
    always_comb begin
        mux_data = '0;
        for (int j = 0; j < N_CODES; j++) begin
            mux_data[j] = decode_code(codes_q[j], in_vec[0]);
        end
    end

    mux_n_to_1 #(
        .SEL_W (SEL_W)
    ) u_mux (
        .data (mux_data),
        .sel  (in_vec[N_IN-1:1]),
        .y    (mux_y)
    );

    // Evaluation acceptance and output/done registers; a restart request in
    // READY takes priority over a simultaneous input.
    always_comb begin
        accept      = (state_q == READY) && in_valid && !cfg_start;
        out_valid_d = accept;
        y_d         = accept ? mux_y : y_q;
        cfg_done_d  = (state_q == FOLD);
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            cnt_q       <= '0;
            table_q     <= '0;
            for (int j = 0; j < N_CODES; j++) begin
                codes_q[j] <= C_ZERO;
            end
            cfg_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            table_q     <= table_d;
            codes_q     <= codes_d;
            cfg_done_q  <= cfg_done_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
        end
    end

    // Drive outputs from their registers.
    always_comb begin
        cfg_done  = cfg_done_q;
        out_valid = out_valid_q;
        y         = y_q;
    end

endmodule

// File: tb/tb_folded_lut_engine.sv
// Self-checking bench for folded_lut_engine (N_IN = 4, CFG_W = 4). The
// reference model is the raw 16-bit truth table: y = tt[in_vec].
module tb_folded_lut_engine;

    localparam int N_IN    = 4;
    localparam int CFG_W   = 4;
    localparam int N_WORDS = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_start;
    logic             cfg_valid;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_ready;
    logic             cfg_done;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_vec;
    logic             out_valid;
    logic             y;

    logic [15:0] model_tt;
    logic        last_y;
    int          checks = 0;
    int          passes = 0;

    folded_lut_engine #(
        .N_IN  (N_IN),
        .CFG_W (CFG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .y         (y)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected bench to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    endtask

    // Drive one cycle of inputs, let the edge happen, settle 1 time unit.
    task automatic applyStimulus(input logic s, input logic cv, input logic [3:0] cd,
                                 input logic iv, input logic [3:0] vec);
        cfg_start = s;
        cfg_valid = cv;
        cfg_data  = cd;
        in_valid  = iv;
        in_vec    = vec;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rnd4();
        return 4'($urandom);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    // Feed words first..last of tt with random idle gaps and stray in_valid.
    task automatic loadWords(input logic [15:0] tt, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                applyStimulus(1'b0, 1'b0, rnd4(), rnd1(), rnd4());
                checkOutput("gap cfg_ready", cfg_ready, 1'b1);
                checkOutput("gap out_valid", out_valid, 1'b0);
            end
            applyStimulus(1'b0, 1'b1, tt[k*4 +: 4], rnd1(), rnd4());
            checkOutput($sformatf("word%0d cfg_ready", k), cfg_ready, (k != N_WORDS - 1));
            checkOutput($sformatf("word%0d out_valid", k), out_valid, 1'b0);
            checkOutput($sformatf("word%0d y hold", k), y, last_y);
        end
    endtask

    // Full table load; with_start = 0 when already in LOADING.
    task automatic loadTable(input logic [15:0] tt, input bit with_start);
        if (with_start) begin
            applyStimulus(1'b1, 1'b0, rnd4(), rnd1(), rnd4());
            checkOutput("start cfg_ready", cfg_ready, 1'b1);
            checkOutput("start out_valid", out_valid, 1'b0);
        end
        loadWords(tt, 0, N_WORDS - 1);
        checkOutput("fold in_ready", in_ready, 1'b0);
        checkOutput("fold cfg_done", cfg_done, 1'b0);
        // Fold cycle: cfg_start, cfg_valid and in_valid are all ignored here.
        applyStimulus(rnd1(), rnd1(), rnd4(), rnd1(), rnd4());
        model_tt = tt;
        checkOutput("done pulse", cfg_done, 1'b1);
        checkOutput("ready in_ready", in_ready, 1'b1);
        checkOutput("ready cfg_ready", cfg_ready, 1'b0);
        checkOutput("ready out_valid", out_valid, 1'b0);
        applyStimulus(1'b0, 1'b0, rnd4(), 1'b0, rnd4());
        checkOutput("done drop", cfg_done, 1'b0);
    endtask

    // One accepted evaluation; in_valid stays high so calls chain back to back.
    task automatic evalOne(input logic [3:0] vec);
        logic exp_y;
        applyStimulus(1'b0, 1'b0, rnd4(), 1'b1, vec);
        exp_y  = model_tt[vec];
        last_y = exp_y;
        checkOutput($sformatf("out_valid vec=%h", vec), out_valid, 1'b1);
        checkOutput($sformatf("y vec=%h tt=%h", vec, model_tt), y, exp_y);
    endtask

    task automatic idleCheck();
        applyStimulus(1'b0, 1'b0, rnd4(), 1'b0, rnd4());
        checkOutput("idle out_valid", out_valid, 1'b0);
        checkOutput("idle y hold", y, last_y);
    endtask

    // Random evaluation traffic with random gaps.
    task automatic runRandom(input int n);
        logic       iv;
        logic [3:0] v;
        for (int i = 0; i < n; i++) begin
            iv = ($urandom_range(0, 3) != 0);
            v  = rnd4();
            if (iv) begin
                evalOne(v);
            end else begin
                applyStimulus(1'b0, 1'b0, rnd4(), 1'b0, v);
                checkOutput("gap out_valid", out_valid, 1'b0);
                checkOutput("gap y hold", y, last_y);
            end
        end
    endtask

    task automatic doReset(input logic iv);
        reset = 1'b1;
        applyStimulus(1'b0, rnd1(), rnd4(), iv, 4'hF);
        reset  = 1'b0;
        last_y = 1'b0;
        checkOutput("rst cfg_ready", cfg_ready, 1'b0);
        checkOutput("rst in_ready", in_ready, 1'b0);
        checkOutput("rst cfg_done", cfg_done, 1'b0);
        checkOutput("rst out_valid", out_valid, 1'b0);
        checkOutput("rst y", y, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        in_valid  = 1'b1;
        in_vec    = 4'hF;
        model_tt  = '0;
        last_y    = 1'b0;

        // Reset with in_valid held high; nothing must respond in EMPTY.
        @(posedge clk);
        #1;
        doReset(1'b1);
        applyStimulus(1'b0, 1'b1, 4'hA, 1'b1, 4'hF);
        checkOutput("empty in_ready", in_ready, 1'b0);
        checkOutput("empty out_valid", out_valid, 1'b0);
        checkOutput("empty cfg_ready", cfg_ready, 1'b0);
        checkOutput("empty y", y, 1'b0);

        // Directed tables.
        loadTable(16'h00FF, 1'b1);
        evalOne(4'b0011);
        evalOne(4'b1000);
        idleCheck();

        loadTable(16'hAAAA, 1'b1);
        evalOne(4'b0101);
        evalOne(4'b1110);
        idleCheck();

        loadTable(16'h6996, 1'b1);
        evalOne(4'b0111);
        evalOne(4'b0110);
        evalOne(4'b1111);
        idleCheck();

        // Random tables and traffic.
        for (int r = 0; r < 4; r++) begin
            loadTable(16'($urandom), 1'b1);
            runRandom(24);
        end

        // Restart mid-load: partial zero words must be discarded.
        applyStimulus(1'b1, 1'b0, rnd4(), 1'b0, rnd4());
        loadWords(16'h0000, 0, 1);
        loadTable(16'hFFFF, 1'b1);
        for (int v = 0; v < 16; v++) begin
            evalOne(4'(v));
        end
        idleCheck();

        // cfg_valid in READY is ignored.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 4'h0, 1'b0, rnd4());
            checkOutput("ready cfg_valid ignored", in_ready, 1'b1);
        end
        for (int v = 0; v < 16; v++) begin
            evalOne(4'(v));
        end

        // Last accept before leaving READY uses old codes; cfg_start beats in_valid.
        evalOne(4'h9);
        applyStimulus(1'b1, 1'b0, rnd4(), 1'b1, 4'h3);
        checkOutput("start-wins out_valid", out_valid, 1'b0);
        checkOutput("start-wins in_ready", in_ready, 1'b0);
        checkOutput("start-wins cfg_ready", cfg_ready, 1'b1);
        checkOutput("start-wins y hold", y, last_y);
        loadTable(16'h1E5C, 1'b0);
        runRandom(20);

        // Reset mid-load, then reload and evaluate.
        applyStimulus(1'b1, 1'b0, rnd4(), 1'b0, rnd4());
        loadWords(16'hF0F0, 0, 1);
        doReset(1'b1);
        loadTable(16'h00FF, 1'b1);
        evalOne(4'b0011);
        evalOne(4'b1000);

        // Reset while an evaluation is in flight drops the output.
        evalOne(4'b0001);
        doReset(1'b1);
        loadTable(16'h00FF, 1'b1);
        evalOne(4'b0011);
        evalOne(4'b1000);
        idleCheck();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
